// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Latency: gnt + uart_enable one cycle after req is sampled in IDLE; done one cycle after uart_busy falls.
// Backpressure: req is held until gnt; no grant while uart_busy is high or a frame is in flight.
// Optional macro UART_ARB_WATCHDOG_EN: gives up after BUSY_TIMEOUT cycles without uart_busy and sets timeout_err.
module uart_tx_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int BUSY_TIMEOUT     = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  done,
    output logic [$clog2(NUM_REQ)-1:0]          owner,
    output logic                                arb_busy,
    output logic                                uart_enable,
    output logic [INPUT_DATA_WIDTH-1:0]         uart_data,
    input  logic                                uart_busy,
    output logic                                timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int W     = INPUT_DATA_WIDTH;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]     N_WIDE   = (IDX_W + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] HOT0     = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..16");
    end
    if (BUSY_TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: BUSY_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_nxt;
    logic [IDX_W-1:0]   owner_nxt;
    logic [IDX_W-1:0]   owner_adv;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] done_nxt;
    logic               uart_enable_nxt;
    logic [W-1:0]       uart_data_nxt;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;
    logic               wd_expire;
    logic [W-1:0]       req_byte [NUM_REQ];

    // Unpack the flat request bus into one byte per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_byte[g] = req_data[g*W +: W];
    end

    assign arb_busy  = (state != IDLE);
    assign owner_adv = (owner == LAST_IDX) ? '0 : owner + IDX_ONE;

`ifdef UART_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] wd_cnt;

    // The counter reads k-1 on the k-th edge spent in WAIT_BUSY, so expiry lands BUSY_TIMEOUT edges after the grant.
    assign wd_expire = (state == WAIT_BUSY) && !uart_busy && (wd_cnt == CNT_LAST);

    // Launch watchdog: cleared outside WAIT_BUSY, sticky error until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT_BUSY) ? wd_cnt + CNT_ONE : '0;
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Round-robin pick: first set req searching upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= N_WIDE) begin
                cand = cand - N_WIDE;
            end
            if (!pick_vld && req[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output decode; pulses default low, data/owner hold.
    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        owner_nxt       = owner;
        gnt_nxt         = '0;
        done_nxt        = '0;
        uart_enable_nxt = 1'b0;
        uart_data_nxt   = uart_data;
        case (state)
            IDLE: begin
                // An externally busy line blocks the launch, which also keeps enable away from busy.
                if (pick_vld && !uart_busy) begin
                    gnt_nxt         = HOT0 << pick_idx;
                    uart_enable_nxt = 1'b1;
                    uart_data_nxt   = req_byte[pick_idx];
                    owner_nxt       = pick_idx;
                    state_nxt       = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wd_expire) begin
                    done_nxt   = HOT0 << owner;
                    rr_ptr_nxt = owner_adv;
                    state_nxt  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    done_nxt   = HOT0 << owner;
                    rr_ptr_nxt = owner_adv;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            gnt         <= '0;
            done        <= '0;
            uart_enable <= 1'b0;
            uart_data   <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            owner       <= owner_nxt;
            gnt         <= gnt_nxt;
            done        <= done_nxt;
            uart_enable <= uart_enable_nxt;
            uart_data   <= uart_data_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a reference model, a UART busy model and directed scenarios.
// Expected grants/dones are queued at the sampling edge and consumed by the monitor on the following negedge.
// Requesters hold req until gnt unless told to keep it high.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;

    logic           clk      = 1'b0;
    logic           reset    = 1'b0;
    logic [N-1:0]   req      = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [1:0]     owner;
    logic           arb_busy;
    logic           uart_enable;
    logic [W-1:0]   uart_data;
    logic           uart_busy;
    logic           timeout_err;
    logic           u_busy   = 1'b0;
    logic           ext_busy = 1'b0;
    logic [N-1:0]   keep     = '0;
    bit             uart_dead = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    assign uart_busy = u_busy | ext_busy;

    uart_tx_arbiter #(
        .NUM_REQ(N), .INPUT_DATA_WIDTH(W), .BUSY_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .owner(owner), .arb_busy(arb_busy),
        .uart_enable(uart_enable), .uart_data(uart_data),
        .uart_busy(uart_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_owner = -1;
    bit           m_seen  = 1'b0;
    int           m_rr    = 0;
    int           m_wait  = 0;
    bit           m_tmo   = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           exp_gnt_q[$];
    logic [W-1:0] exp_dat_q[$];
    int           exp_done_q[$];

    function automatic int rr_pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic finish_txn();
        exp_done_q.push_back(m_owner);
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1;
            m_rr    = 0;
            m_tmo   = 1'b0;
            m_data  = '0;
            exp_gnt_q.delete();
            exp_dat_q.delete();
            exp_done_q.delete();
        end else if (m_owner < 0) begin
            if (req != '0 && !uart_busy) begin
                m_owner = rr_pick(req, m_rr);
                m_seen  = 1'b0;
                m_wait  = 0;
                m_data  = req_data[m_owner*W +: W];
                exp_gnt_q.push_back(m_owner);
                exp_dat_q.push_back(m_data);
            end
        end else if (!m_seen) begin
            if (uart_busy) m_seen = 1'b1;
`ifdef UART_ARB_WATCHDOG_EN
            else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_tmo = 1'b1;
                    finish_txn();
                end
            end
`endif
        end else if (!uart_busy) begin
            finish_txn();
        end
    end

    // ---------------- monitor ----------------
    int           gnt_log[$];
    logic [W-1:0] data_log[$];
    int           done_log[$];

    always @(negedge clk) begin
        int           e;
        logic [W-1:0] d;
        if (reset) begin
            if (exp_gnt_q.size() > 0) begin
                e = exp_gnt_q.pop_front();
                d = exp_dat_q.pop_front();
                check("gnt", gnt, 32'(1 << e));
                check("enable_with_gnt", uart_enable, 1);
                check("gnt_data", uart_data, d);
                check("owner", owner, e);
                gnt_log.push_back(int'(owner));
                data_log.push_back(uart_data);
            end else if (gnt != '0 || uart_enable) begin
                check("spurious_gnt", {gnt, uart_enable}, 0);
            end
            if (exp_done_q.size() > 0) begin
                e = exp_done_q.pop_front();
                check("done", done, 32'(1 << e));
                for (int i = 0; i < N; i++) if (done[i]) done_log.push_back(i);
            end else if (done != '0) begin
                check("spurious_done", done, 0);
            end
            check("arb_busy", arb_busy, (m_owner >= 0) ? 1 : 0);
            check("timeout_err", timeout_err, m_tmo);
            check("uart_data_hold", uart_data, m_data);
            check("enable_vs_busy", uart_enable & uart_busy, 0);
        end
    end

    // ---------------- UART busy model ----------------
    int           u_state = 0;
    int           u_cnt   = 0;
    logic [W-1:0] u_latch = '0;
    logic [W-1:0] rx_log[$];

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            u_state = 0;
            u_busy  = 1'b0;
        end else begin
            case (u_state)
                0: if (uart_enable && !uart_dead) begin
                    u_latch = uart_data;
                    u_cnt   = $urandom_range(3, 1);
                    u_state = 1;
                end
                1: begin
                    u_cnt--;
                    if (u_cnt == 0) begin
                        u_busy  = 1'b1;
                        u_cnt   = $urandom_range(8, 3);
                        u_state = 2;
                    end
                end
                default: begin
                    check("frame_data_stable", uart_data, u_latch);
                    u_cnt--;
                    if (u_cnt == 0) begin
                        u_busy  = 1'b0;
                        rx_log.push_back(u_latch);
                        u_state = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && !keep[i]) req[i] = 1'b0;
        end
    endtask

    task automatic raise(input int i, input logic [W-1:0] b);
        req_data[i*W +: W] = b;
        req[i] = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string name);
        int c = 0;
        while (gnt_log.size() < n && c < 300) begin
            tick();
            c++;
        end
        check(name, gnt_log.size(), n);
    endtask

    task automatic wait_quiet(input string name);
        int c = 0;
        while (!(m_owner < 0 && req == '0 && u_state == 0) && c < 500) begin
            tick();
            c++;
        end
        check(name, (c < 500) ? 1 : 0, 1);
    endtask

    function automatic int log_at(input int k);
        return (k < gnt_log.size()) ? gnt_log[k] : -1;
    endfunction

    // ---------------- scenarios ----------------
    initial begin
        logic [W-1:0] fair_bytes [5];
        int           fair_order [5];
        int           sticky_order [3];
        fair_bytes   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        fair_order   = '{0, 1, 2, 3, 0};
        sticky_order = '{0, 3, 0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_enable", uart_enable, 0);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_data", uart_data, 0);
        check("rst_owner", owner, 0);
        check("rst_timeout", timeout_err, 0);
        reset = 1'b1;
        repeat (2) tick();

        // all requesters held high: strict rotation from 0
        keep = '1;
        for (int i = 0; i < N; i++) raise(i, 8'h10 + 8'(i));
        gnt_log.delete();
        rx_log.delete();
        wait_grants(5, "fair_count");
        keep = '0;
        req  = '0;
        wait_quiet("fair_quiet");
        for (int k = 0; k < 5; k++) begin
            check("fair_order", log_at(k), fair_order[k]);
            check("fair_rx", (k < rx_log.size()) ? 32'(rx_log[k]) : 32'hFFFF, fair_bytes[k]);
        end

        // single request from requester 2
        gnt_log.delete();
        data_log.delete();
        done_log.delete();
        raise(2, 8'hA5);
        wait_grants(1, "single_count");
        wait_quiet("single_quiet");
        check("single_owner", log_at(0), 2);
        check("single_data", (data_log.size() > 0) ? 32'(data_log[0]) : 32'hFFFF, 8'hA5);
        check("single_done", (done_log.size() > 0) ? done_log[0] : -1, 2);

        // move the pointer back to 0, then requester 0 keeps req high against pending 3
        raise(3, 8'h33);
        wait_quiet("rr_setup_quiet");
        gnt_log.delete();
        keep[0] = 1'b1;
        raise(0, 8'h50);
        raise(3, 8'h53);
        wait_grants(3, "sticky_count");
        keep = '0;
        req  = '0;
        wait_quiet("sticky_quiet");
        for (int k = 0; k < 3; k++) check("sticky_order", log_at(k), sticky_order[k]);

        // line externally busy: no grant until it clears
        gnt_log.delete();
        ext_busy = 1'b1;
        raise(1, 8'h77);
        repeat (20) tick();
        check("ext_busy_hold", gnt_log.size(), 0);
        ext_busy = 1'b0;
        wait_grants(1, "ext_busy_count");
        check("ext_busy_owner", log_at(0), 1);
        wait_quiet("ext_busy_quiet");

        // randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && !gnt[i] && $urandom_range(3, 0) == 0) raise(i, 8'($urandom));
            end
        end
        wait_quiet("random_quiet");

        // reset during WAIT_DONE with requesters 1 and 3 pending and rr_ptr at 2
        raise(1, 8'h61);
        wait_quiet("mid_setup_quiet");
        gnt_log.delete();
        raise(2, 8'h62);
        wait_grants(1, "mid_grant");
        raise(1, 8'h71);
        raise(3, 8'h73);
        for (int c = 0; c < 20 && u_state != 2; c++) tick();
        check("mid_frame_started", u_state, 2);
        tick();
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_enable", uart_enable, 0);
        check("mid_rst_arb_busy", arb_busy, 0);
        check("mid_rst_data", uart_data, 0);
        check("mid_rst_owner", owner, 0);
        tick();
        reset = 1'b1;
        gnt_log.delete();
        wait_grants(1, "post_rst_count");
        check("post_rst_owner", log_at(0), 1);
        wait_quiet("post_rst_quiet");

        // UART never raises busy after launch
        gnt_log.delete();
        done_log.delete();
        uart_dead = 1'b1;
        raise(0, 8'h0F);
        wait_grants(1, "stuck_grant");
        repeat (100) tick();
`ifdef UART_ARB_WATCHDOG_EN
        check("stuck_done", (done_log.size() > 0) ? done_log[0] : -1, 0);
        check("stuck_timeout", timeout_err, 1);
        check("stuck_idle", arb_busy, 0);
`else
        check("stuck_no_done", done_log.size(), 0);
        check("stuck_timeout", timeout_err, 0);
        check("stuck_waiting", arb_busy, 1);
`endif
        #1;
        reset = 1'b0;
        #1;
        check("final_rst_timeout", timeout_err, 0);
        check("final_rst_arb_busy", arb_busy, 0);
        uart_dead = 1'b0;
        tick();
        reset = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (enable / i_data / o_busy interface) between N requesters using round-robin arbitration.
- Latches the winner's byte and pulses the UART enable for exactly one cycle.
- Holds i_data stable for the whole frame, then reports completion to the owning requester.
- Sits between the system-side byte producers and the UART top level. It is the only block that drives the UART enable and i_data.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- INPUT_DATA_WIDTH, 8, byte width; must equal the UART data width
- BUSY_TIMEOUT, 64, cycles to wait for uart_busy to rise after launch (used only with the optional feature)

Ports:
- clk  in  1  system clock; the same clock as the UART
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester transmit request; held high until gnt
- req_data  in  NUM_REQ*INPUT_DATA_WIDTH  packed bytes; requester i occupies slice [i*W +: W]; stable while req[i] is high
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: byte accepted
- done  out  NUM_REQ  one-hot, one-cycle pulse: frame finished on the line
- owner  out  clog2(NUM_REQ)  index of the current/last granted requester
- arb_busy  out  1  high in any state other than IDLE
- uart_enable  out  1  to UART enable; one-cycle pulse
- uart_data  out  INPUT_DATA_WIDTH  to UART i_data
- uart_busy  in  1  from UART o_busy
- timeout_err  out  1  sticky error flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (reset==0, asynchronous):
  - State = IDLE; rr_ptr = 0.
  - gnt, done, uart_enable, arb_busy and timeout_err = 0; uart_data = 0; owner = 0.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - At an edge where |req && !uart_busy: select the first set req[i] searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register gnt[i]=1, uart_enable=1, uart_data=req_data slice i, owner=i. Go to WAIT_BUSY.
  - gnt and uart_enable are high together in the cycle after the request is sampled, for exactly one cycle.
  - If uart_busy==1 in IDLE, no grant is made (the line is externally busy).
- WAIT_BUSY: stay until uart_busy==1, then go to WAIT_DONE. The UART may take up to one baud period to raise o_busy.
- WAIT_DONE:
  - Stay while uart_busy==1.
  - On the first cycle uart_busy==0: pulse done[owner] for one cycle, set rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
- uart_data:
  - Changes only on a grant edge; constant from grant until the next grant, so it is stable across the whole frame.
- Requester side:
  - A requester must deassert req[i] in the cycle after gnt[i].
  - A req still high after its gnt is treated as a new request. Because of rr_ptr it is served only after all other pending requesters.
- Grant spacing: minimum spacing between two grants is one idle cycle after done.
- Fairness: with all requests permanently high, the grant order is 0,1,2,…,N-1,0,…
- Requests arriving in non-IDLE states are ignored until IDLE. No request is lost as long as req is held.
- Simultaneous done and new req in the same cycle: the grant is evaluated in IDLE on the following edge.
- Reset mid-frame:
  - The arbiter returns to IDLE immediately and drives no done pulse.
  - The UART is reset by the same reset.
- uart_enable is never asserted while uart_busy==1.

Optional Feature:
- Macro: UART_ARB_WATCHDOG_EN.
- Defined:
  - A counter runs in WAIT_BUSY.
  - If uart_busy has not risen after BUSY_TIMEOUT cycles: set timeout_err=1 (sticky until reset), pulse done[owner], advance rr_ptr, return to IDLE.
  - The counter clears on entry to WAIT_BUSY.
- Not defined: no counter; WAIT_BUSY waits indefinitely; timeout_err tied to 0.

Test Plan:
- Single request: req=4'b0100, data[2]=8'hA5 -> one-cycle gnt=4'b0100 with uart_enable=1 and uart_data=8'hA5. uart_data holds 8'hA5 until done=4'b0100, which comes one cycle after uart_busy falls. owner=2.
- All four requesting continuously, bytes 8'h10..8'h13 -> grant order 0,1,2,3,0. Looped-back UART receives 8'h10,8'h11,8'h12,8'h13 in order with no rx_error.
- req asserted while uart_busy=1 in IDLE -> no gnt until uart_busy=0. uart_enable never coincides with uart_busy=1.
- Reset pulled low during WAIT_DONE -> all outputs 0 and state IDLE asynchronously. After release, a pending req[1] is granted normally with rr_ptr starting at 0.
- With UART_ARB_WATCHDOG_EN, BUSY_TIMEOUT=64, uart_busy stuck 0 -> done pulses 64 cycles after grant and timeout_err=1 stays set. Without the macro, the arbiter stays in WAIT_BUSY and timeout_err=0.
- Requester 0 keeps req high after gnt while req[3] is pending -> the next grant goes to 3, then 0.
